// File: rtl/quick_uart_pkg.sv
// Shared types and helpers for the quick_uart transmitter and receiver.
package quick_uart_pkg;

    typedef enum logic [2:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop,
        RxWaitIdle
    } uart_rx_state_t;

    typedef enum logic [1:0] {
        TxIdle,
        TxStart,
        TxData,
        TxStop
    } uart_tx_state_t;

    // Width of a counter able to index the longest field of a frame.
    function automatic int unsigned frame_cnt_width(input int unsigned start_bits,
                                                    input int unsigned data_bits,
                                                    input int unsigned stop_bits);
        int unsigned m;
        m = start_bits;
        if (data_bits > m) m = data_bits;
        if (stop_bits > m) m = stop_bits;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q = RESET_VALUE;
    logic sync_q = RESET_VALUE;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RESET_VALUE;
            sync_q <= RESET_VALUE;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/timer.sv
// Down-counting interval timer: done_o fires count_i cycles after start_i.
module timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] count_i,
    output logic             done_o
);

    logic [WIDTH-1:0] cnt_q = '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (start_i) begin
            cnt_q <= count_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/quick_uart_rx.sv
// UART receiver: mid-bit sampling, LSB-first reassembly, one-word holding register
// with valid/ready output and framing/overrun pulses.
module quick_uart_rx
    import quick_uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100000000,
    parameter int unsigned BAUD       = 115200,
    parameter int unsigned DIV        = CLK_FREQ / BAUD,
    parameter logic        IDLE_VALUE = 1'b1,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned START_BITS = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rx_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 frame_err_o,
    output logic                 overrun_o
);

    localparam int unsigned CntW = frame_cnt_width(START_BITS, DATA_BITS, STOP_BITS);
    localparam int unsigned TmrW = $clog2(DIV) + 1;
    localparam logic [TmrW-1:0] DivFull = TmrW'(DIV);
    localparam logic [TmrW-1:0] DivHalf = TmrW'(DIV / 2);
    localparam logic [CntW-1:0] StartLast = CntW'(START_BITS - 1);
    localparam logic [CntW-1:0] DataLast  = CntW'(DATA_BITS - 1);
    localparam logic [CntW-1:0] StopLast  = CntW'(STOP_BITS - 1);

    if (DIV < 4) begin : g_div_chk
        $error("quick_uart_rx: DIV must be >= 4");
    end

    uart_rx_state_t       state_q     = RxIdle;
    logic [CntW-1:0]      bit_cnt_q   = '0;
    logic [DATA_BITS-1:0] shift_q     = '0;
    logic [DATA_BITS-1:0] shift_d;
    logic [DATA_BITS-1:0] hold_q      = '0;
    logic                 valid_q     = 1'b0;
    logic                 frame_err_q = 1'b0;
    logic                 overrun_q   = 1'b0;

    logic            rx_s;
    logic            tick;
    logic            timer_start;
    logic [TmrW-1:0] timer_count;

    sync_2ff #(
        .RESET_VALUE(IDLE_VALUE)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (rx_i),
        .q_o  (rx_s)
    );

    timer #(
        .WIDTH(TmrW)
    ) u_timer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(timer_start),
        .count_i(timer_count),
        .done_o (tick)
    );

    // Half-period load on the start edge puts every later sample at mid-bit.
    always_comb begin
        timer_count = (state_q == RxIdle) ? DivHalf : DivFull;
        timer_start = 1'b0;
        if (state_q == RxIdle) begin
            timer_start = (rx_s != IDLE_VALUE);
        end else if (state_q != RxWaitIdle) begin
            timer_start = tick;
        end
        shift_d = shift_q >> 1;
        shift_d[DATA_BITS-1] = rx_s;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= RxIdle;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (valid_q && ready_i) valid_q <= 1'b0;
            case (state_q)
                RxIdle: begin
                    if (rx_s != IDLE_VALUE) begin
                        state_q   <= RxStart;
                        bit_cnt_q <= '0;
                    end
                end
                RxStart: begin
                    if (tick) begin
                        if (rx_s == IDLE_VALUE) begin
                            state_q <= RxIdle;
                        end else if (bit_cnt_q == StartLast) begin
                            state_q   <= RxData;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                RxData: begin
                    if (tick) begin
                        shift_q <= shift_d;
                        if (bit_cnt_q == DataLast) begin
                            state_q   <= RxStop;
                            bit_cnt_q <= '0;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                RxStop: begin
                    if (tick) begin
                        if (rx_s != IDLE_VALUE) begin
                            frame_err_q <= 1'b1;
                            state_q     <= RxWaitIdle;
                        end else if (bit_cnt_q == StopLast) begin
                            state_q <= RxIdle;
                            // An accept in this same cycle frees the holding register.
                            if (!valid_q || ready_i) begin
                                hold_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end
                end
                RxWaitIdle: begin
                    if (rx_s == IDLE_VALUE) state_q <= RxIdle;
                end
                default: state_q <= RxIdle;
            endcase
        end
    end

    assign valid_o     = valid_q;
    assign data_o      = hold_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule
